opti_sos_issuer: RTL and testbench
==================================

Name: opti_sos_issuer

Overview:
- Initiator side of the biquad-section sample handshake.
- Accepts input samples from upstream on a valid/ready interface and issues each one to the second-order-section chain as a single-cycle data valid pulse.
- Waits for the chain's output valid, captures the result and holds it for the downstream consumer.
- Enforces one sample in flight, a minimum issue spacing, and a response timeout.

Parameters:
DW, 24, sample width (signed Q format, passed through unmodified)
MIN_GAP, 4, minimum idle cycles between consecutive issue pulses (1..255)
TIMEOUT, 64, cycles allowed from issue pulse to section response (2..65535)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
s_data  in  DW  upstream sample
s_valid  in  1  upstream sample valid
s_ready  out  1  issuer can accept a sample
sos_data_in  out  DW  sample driven to the section chain
sos_valid_in  out  1  one-cycle issue pulse to the section chain
sos_data_out  in  DW  result from the last section
sos_valid_out  in  1  result valid from the last section
m_data  out  DW  filtered sample to downstream
m_valid  out  1  filtered sample valid
m_ready  in  1  downstream accepts
busy  out  1  state != IDLE
timeout_err  out  1  sticky: a section response was missed
sample_cnt  out  16  count of samples delivered downstream, wraps 0xFFFF->0

Behaviour:
- Single clock (clk); reset is synchronous and active-high (rst). rst dominates every other input in the same cycle.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Gap counter and timer are 0.
  - An in-flight sample is dropped.
- State machine: IDLE, WAIT, HOLD. All outputs are registered except s_ready and busy, which decode from state and counters.
- IDLE:
  - s_ready = 1 only when gap counter == 0.
  - If s_valid && s_ready at cycle A: at A+1, sos_data_in = s_data, sos_valid_in = 1, state = WAIT, timer = 0.
- Issue pulse: sos_valid_in is high for exactly one cycle per accepted sample and is never high outside that cycle. sos_data_in holds the last issued value between issues.
- Gap counter:
  - Loaded with MIN_GAP in the pulse cycle, then decrements by 1 per cycle, saturating at 0.
  - Consecutive sos_valid_in pulses are therefore separated by at least MIN_GAP+1 cycles.
- WAIT:
  - s_ready = 0. Timer increments each cycle.
  - If sos_valid_out: m_data <= sos_data_out and m_valid <= 1 next cycle, state = HOLD.
  - A response in the pulse cycle itself is accepted.
  - If timer == TIMEOUT-1 and no sos_valid_out: timeout_err <= 1, state <= IDLE, no downstream output.
  - A response arriving on the timeout cycle wins over the timeout.
- HOLD:
  - m_valid = 1; m_data is stable until m_valid && m_ready.
  - On handshake: m_valid <= 0, sample_cnt++, state <= IDLE.
  - m_ready is ignored while m_valid = 0.
- sos_valid_out outside WAIT (stray, or late after timeout) is ignored. It has no effect on m_data, m_valid or sample_cnt.
- timeout_err clears only on rst.
- Latency with section response latency L (response at P+L, pulse at P) and m_ready high: m_valid rises at P+L+1.
- No arithmetic is performed on data. Widths pass through bit-exact; saturation is the section's responsibility.

Test Plan:
1. Single sample: s_data = 24'h100000 accepted at cycle A; model responds 24'h080000 at A+3 -> sos_valid_in pulse only at A+1 with 24'h100000; m_valid = 1, m_data = 24'h080000 at A+4; with m_ready = 1, sample_cnt = 1 at A+5.
2. Backpressure: m_ready = 0 for 10 cycles in HOLD -> m_valid and m_data are stable; s_ready = 0; no second sos_valid_in. On m_ready = 1, the handshake completes and sample_cnt increments exactly once.
3. Timeout (TIMEOUT = 64): section silent after pulse at P -> timeout_err = 1 from P+64; state returns to IDLE; m_valid never asserts. A sos_valid_out at P+70 is ignored. The next upstream sample is accepted normally and timeout_err stays 1.
4. Gap enforcement (MIN_GAP = 4): model responds next cycle, s_valid and m_ready held high -> pulses at P, P+5, P+10 with no closer spacing; 3 samples delivered in order.
5. Stray and boundary: sos_valid_out asserted in IDLE -> m_valid stays 0. sample_cnt preset by 65535 deliveries -> the next delivery wraps it to 0.
6. Reset mid-operation: rst high for 1 cycle during WAIT -> the next cycle all outputs are 0 and state is IDLE. A subsequent sos_valid_out for the dropped sample is ignored.

Source files
------------

// File: rtl/opti_sos_issuer_if.sv
// opti_sos_issuer_if: upstream, section-chain and downstream sample handshake bundle
interface opti_sos_issuer_if #(parameter int DW = 24);
  logic [DW-1:0] s_data, sos_data_in, sos_data_out, m_data;
  logic s_valid, s_ready, sos_valid_in, sos_valid_out, m_valid, m_ready;
  modport master (
    input  s_data, s_valid, sos_data_out, sos_valid_out, m_ready,
    output s_ready, sos_data_in, sos_valid_in, m_data, m_valid
  );
  modport slave (
    output s_data, s_valid, sos_data_out, sos_valid_out, m_ready,
    input  s_ready, sos_data_in, sos_valid_in, m_data, m_valid
  );
endinterface

// File: rtl/opti_sos_issuer.sv
// opti_sos_issuer: issues one sample at a time to a biquad chain with spacing and response timeout
module opti_sos_issuer #(
  parameter int DW      = 24,
  parameter int MIN_GAP = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  opti_sos_issuer_if.master     bus,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [15:0]           sample_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [7:0] gap_q, gap_d;
  logic [15:0] timer_q, timer_d, cnt_q, cnt_d;
  logic [DW-1:0] sos_data_q, sos_data_d, m_data_q, m_data_d;
  logic sos_valid_q, sos_valid_d, m_valid_q, m_valid_d, err_q, err_d;
  logic accept;
  assign bus.s_ready      = state_q == IDLE && gap_q == 8'd0;
  assign accept           = bus.s_valid && bus.s_ready;
  assign busy             = state_q != IDLE;
  assign bus.sos_data_in  = sos_data_q;
  assign bus.sos_valid_in = sos_valid_q;
  assign bus.m_data       = m_data_q;
  assign bus.m_valid      = m_valid_q;
  assign timeout_err      = err_q;
  assign sample_cnt       = cnt_q;
  // next state: issue on accept, capture or time out while waiting, release on downstream handshake
  always_comb begin
    state_d     = state_q;
    gap_d       = accept ? 8'(MIN_GAP) : (gap_q != 8'd0 ? gap_q - 8'd1 : gap_q);
    timer_d     = state_q == WAIT ? timer_q + 16'd1 : 16'd0;
    sos_valid_d = accept;
    sos_data_d  = accept ? bus.s_data : sos_data_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: if (accept) state_d = WAIT;
      WAIT: begin
        if (bus.sos_valid_out) begin
          m_valid_d = 1'b1;
          m_data_d  = bus.sos_data_out;
          state_d   = HOLD;
        end else if (timer_q == 16'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: if (bus.m_ready) begin
        m_valid_d = 1'b0;
        cnt_d     = cnt_q + 16'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset drops any in-flight sample
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      timer_q     <= '0;
      sos_valid_q <= 1'b0;
      sos_data_q  <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      timer_q     <= timer_d;
      sos_valid_q <= sos_valid_d;
      sos_data_q  <= sos_data_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_opti_sos_issuer.sv
// tb_opti_sos_issuer: directed plus randomized checks against a cycle-count reference model
module tb_opti_sos_issuer;
  localparam int MIN_GAP = 4;
  localparam int TIMEOUT = 64;
  logic clk = 1'b0;
  logic rst;
  logic busy, timeout_err;
  logic [15:0] sample_cnt;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit e_w, e_mv, e_sv, e_err;
  logic [23:0] e_sd, e_md;
  logic [15:0] e_cnt;
  int last_pulse, issue;
  int pulses[$];
  bit prev;
  logic [23:0] v2;
  always #5 clk = ~clk;
  opti_sos_issuer_if #(.DW(24)) bus ();
  opti_sos_issuer #(.DW(24), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .timeout_err(timeout_err), .sample_cnt(sample_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic bit model_ready();
    return !e_w && !e_mv && (cyc - last_pulse >= MIN_GAP);
  endfunction
  task automatic model_step();
    bit rdy, nw, nmv;
    rdy = model_ready();
    nw  = e_w;
    nmv = e_mv;
    if (rst) begin
      nw = 0; nmv = 0; e_sv = 0; e_err = 0; e_sd = '0; e_md = '0; e_cnt = '0;
      last_pulse = -1000;
    end else begin
      e_sv = 0;
      if (bus.s_valid && rdy) begin
        e_sv = 1; e_sd = bus.s_data; last_pulse = cyc + 1; issue = cyc + 1; nw = 1;
      end
      if (e_w) begin
        if (bus.sos_valid_out) begin
          nw = 0; nmv = 1; e_md = bus.sos_data_out;
        end else if (cyc - issue == TIMEOUT - 1) begin
          nw = 0; e_err = 1;
        end
      end
      if (e_mv && bus.m_ready) begin
        nmv = 0; e_cnt = e_cnt + 16'd1;
      end
    end
    e_w  = nw;
    e_mv = nmv;
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("sos_valid_in", 32'(bus.sos_valid_in), 32'(e_sv));
    chk("sos_data_in", 32'(bus.sos_data_in), 32'(e_sd));
    chk("m_valid", 32'(bus.m_valid), 32'(e_mv));
    chk("m_data", 32'(bus.m_data), 32'(e_md));
    chk("timeout_err", 32'(timeout_err), 32'(e_err));
    chk("sample_cnt", 32'(sample_cnt), 32'(e_cnt));
    chk("s_ready", 32'(bus.s_ready), 32'(model_ready()));
    chk("busy", 32'(busy), 32'(e_w || e_mv));
    @(negedge clk);
  endtask
  initial begin
    rst = 1; bus.s_valid = 0; bus.s_data = '0; bus.sos_valid_out = 0; bus.sos_data_out = '0; bus.m_ready = 1;
    last_pulse = -1000; issue = 0;
    @(negedge clk);
    tick();
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 0;
    tick();
    // single sample, section latency 2
    bus.s_valid = 1; bus.s_data = 24'h100000;
    tick();
    bus.s_valid = 0;
    chk("t1_pulse", 32'(bus.sos_valid_in), 32'd1);
    chk("t1_sdata", 32'(bus.sos_data_in), 32'h100000);
    tick();
    chk("t1_pulse_once", 32'(bus.sos_valid_in), 32'd0);
    tick();
    bus.sos_valid_out = 1; bus.sos_data_out = 24'h080000;
    tick();
    bus.sos_valid_out = 0;
    chk("t1_m_valid", 32'(bus.m_valid), 32'd1);
    chk("t1_m_data", 32'(bus.m_data), 32'h080000);
    tick();
    chk("t1_cnt", 32'(sample_cnt), 32'd1);
    // downstream backpressure
    bus.m_ready = 0; bus.s_valid = 1; v2 = 24'($urandom); bus.s_data = 24'($urandom);
    tick();
    bus.sos_valid_out = 1; bus.sos_data_out = v2;
    tick();
    bus.sos_valid_out = 0;
    repeat (10) begin
      tick();
      chk("t2_hold_valid", 32'(bus.m_valid), 32'd1);
      chk("t2_hold_data", 32'(bus.m_data), 32'(v2));
      chk("t2_no_ready", 32'(bus.s_ready), 32'd0);
      chk("t2_no_pulse", 32'(bus.sos_valid_in), 32'd0);
    end
    bus.s_valid = 0; bus.m_ready = 1;
    tick();
    chk("t2_cnt", 32'(sample_cnt), 32'd2);
    chk("t2_released", 32'(bus.m_valid), 32'd0);
    // silent section, then a late response
    bus.s_valid = 1; bus.s_data = 24'h7ABCDE;
    tick();
    bus.s_valid = 0;
    repeat (63) tick();
    chk("t3_err_early", 32'(timeout_err), 32'd0);
    tick();
    chk("t3_err", 32'(timeout_err), 32'd1);
    chk("t3_idle", 32'(busy), 32'd0);
    repeat (6) tick();
    bus.sos_valid_out = 1; bus.sos_data_out = 24'h123456;
    tick();
    bus.sos_valid_out = 0;
    chk("t3_late_ignored", 32'(bus.m_valid), 32'd0);
    bus.s_valid = 1; bus.s_data = 24'h654321;
    tick();
    bus.s_valid = 0;
    chk("t3_reaccept", 32'(bus.sos_valid_in), 32'd1);
    bus.sos_valid_out = 1; bus.sos_data_out = 24'h0F0F0F;
    tick();
    bus.sos_valid_out = 0;
    chk("t3_m_valid", 32'(bus.m_valid), 32'd1);
    chk("t3_err_sticky", 32'(timeout_err), 32'd1);
    tick();
    chk("t3_cnt", 32'(sample_cnt), 32'd3);
    // issue spacing with back-to-back demand
    prev = 0; bus.s_valid = 1; bus.m_ready = 1;
    repeat (16) begin
      bus.sos_valid_out = prev; bus.sos_data_out = 24'($urandom); bus.s_data = 24'($urandom);
      tick();
      prev = bus.sos_valid_in;
      if (prev) pulses.push_back(cyc);
    end
    bus.s_valid = 0; bus.sos_valid_out = prev;
    tick();
    bus.sos_valid_out = 0;
    repeat (3) tick();
    chk("t4_npulses", 32'(pulses.size() >= 3), 32'd1);
    for (int i = 1; i < pulses.size(); i++) chk("t4_spacing", 32'(pulses[i] - pulses[i-1]), 32'(MIN_GAP + 1));
    // stray response in idle, then counter wrap
    bus.sos_valid_out = 1;
    repeat (3) tick();
    bus.sos_valid_out = 0;
    chk("t5_stray", 32'(bus.m_valid), 32'd0);
    force dut.cnt_q = 16'hFFFF;
    e_cnt = 16'hFFFF;
    tick();
    release dut.cnt_q;
    bus.s_valid = 1; bus.s_data = 24'h000001;
    tick();
    bus.s_valid = 0; bus.sos_valid_out = 1; bus.sos_data_out = 24'hFFFFFF;
    tick();
    bus.sos_valid_out = 0;
    tick();
    chk("t5_wrap", 32'(sample_cnt), 32'd0);
    // reset while waiting drops the sample
    repeat (4) tick();
    bus.s_valid = 1; bus.s_data = 24'h222222;
    tick();
    bus.s_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_err", 32'(timeout_err), 32'd0);
    chk("t6_cnt", 32'(sample_cnt), 32'd0);
    bus.sos_valid_out = 1; bus.sos_data_out = 24'h333333;
    tick();
    bus.sos_valid_out = 0;
    chk("t6_dropped", 32'(bus.m_valid), 32'd0);
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst = $urandom_range(0, 299) == 0;
      bus.s_valid = $urandom_range(0, 1) == 1;
      bus.s_data = 24'($urandom);
      bus.sos_valid_out = (n % 700) < 600 && $urandom_range(0, 9) == 0;
      bus.sos_data_out = 24'($urandom);
      bus.m_ready = $urandom_range(0, 2) != 0;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
